// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter_if : two-master request/response bus plus the shared-RAM port
// Rev 1.0
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
  logic        m0_valid;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wmask;
  logic        m0_ready;
  logic [31:0] m0_rdata;

  logic        m1_valid;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [3:0]  m1_wmask;
  logic        m1_ready;
  logic [31:0] m1_rdata;

  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wmask,
    input  m1_valid, m1_addr, m1_wdata, m1_wmask,
    input  mem_rdata,
    output m0_ready, m0_rdata, m1_ready, m1_rdata,
    output mem_addr, mem_rstrb, mem_wdata, mem_wmask
  );

  // Masters plus RAM, as seen from outside the arbiter
  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wmask,
    output m1_valid, m1_addr, m1_wdata, m1_wmask,
    output mem_rdata,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata,
    input  mem_addr, mem_rstrb, mem_wdata, mem_wmask
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : two-master, three-cycle arbiter in front of one registered RAM
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t      state_q,    state_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [3:0]  wmask_q,    wmask_d;
  logic        gnt_q,      gnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;

  logic win;
  logic access_act;
  logic respond_act;

  always_comb begin
    if (bus.m0_valid && bus.m1_valid) begin
      win = (ROUND_ROBIN != 0) ? ~last_gnt_q : 1'b0;
    end else begin
      win = bus.m1_valid;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_valid || bus.m1_valid) begin
          addr_d  = win ? bus.m1_addr  : bus.m0_addr;
          wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
          wmask_d = win ? bus.m1_wmask : bus.m0_wmask;
          gnt_d   = win;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESPOND;
      end
      RESPOND: begin
        last_gnt_d = gnt_q;
        if (gnt_q) begin
          m1_rdata_d = bus.mem_rdata;
        end else begin
          m0_rdata_d = bus.mem_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wmask_q    <= 4'd0;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      m0_rdata_q <= 32'd0;
      m1_rdata_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // Strobes and ready are masked while reset is high so an aborted
  // transaction never reaches the RAM or a master in the reset cycle.
  assign access_act  = (state_q == ACCESS)  && !reset;
  assign respond_act = (state_q == RESPOND) && !reset;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rstrb = access_act && (wmask_q == 4'd0);
  assign bus.mem_wmask = access_act ? wmask_q : 4'd0;

  assign bus.m0_ready  = respond_act && !gnt_q;
  assign bus.m1_ready  = respond_act &&  gnt_q;
  assign bus.m0_rdata  = bus.m0_ready ? bus.mem_rdata : m0_rdata_q;
  assign bus.m1_rdata  = bus.m1_ready ? bus.mem_rdata : m1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : directed table, contention sequences and random traffic
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam logic [31:0] W100 = 32'h04030201;
  localparam logic [31:0] W101 = 32'h08070605;
  localparam logic [31:0] W102 = 32'h0C0B0A09;
  localparam logic [31:0] WB   = 32'hAA070605;

  logic clk = 1'b0;
  logic reset;
  logic sel;
  always #5 clk = ~clk;

  logic        v0, v1;
  logic [31:0] a0, a1, d0, d1;
  logic [3:0]  k0, k1;
  logic [31:0] mem_rdata;

  mem_arbiter_if bus_rr ();
  mem_arbiter_if bus_fx ();

  mem_arbiter #(.ROUND_ROBIN(1)) dut_rr (.clk(clk), .reset(reset), .bus(bus_rr));
  mem_arbiter #(.ROUND_ROBIN(0)) dut_fx (.clk(clk), .reset(reset), .bus(bus_fx));

  assign bus_rr.m0_valid = v0 & ~sel;
  assign bus_fx.m0_valid = v0 &  sel;
  assign bus_rr.m1_valid = v1 & ~sel;
  assign bus_fx.m1_valid = v1 &  sel;
  assign bus_rr.m0_addr  = a0;  assign bus_fx.m0_addr  = a0;
  assign bus_rr.m1_addr  = a1;  assign bus_fx.m1_addr  = a1;
  assign bus_rr.m0_wdata = d0;  assign bus_fx.m0_wdata = d0;
  assign bus_rr.m1_wdata = d1;  assign bus_fx.m1_wdata = d1;
  assign bus_rr.m0_wmask = k0;  assign bus_fx.m0_wmask = k0;
  assign bus_rr.m1_wmask = k1;  assign bus_fx.m1_wmask = k1;
  assign bus_rr.mem_rdata = mem_rdata;
  assign bus_fx.mem_rdata = mem_rdata;

  logic        r0, r1, rs;
  logic [3:0]  wm;
  logic [31:0] oaddr, owd, rd0, rd1;
  assign r0    = sel ? bus_fx.m0_ready  : bus_rr.m0_ready;
  assign r1    = sel ? bus_fx.m1_ready  : bus_rr.m1_ready;
  assign rs    = sel ? bus_fx.mem_rstrb : bus_rr.mem_rstrb;
  assign wm    = sel ? bus_fx.mem_wmask : bus_rr.mem_wmask;
  assign oaddr = sel ? bus_fx.mem_addr  : bus_rr.mem_addr;
  assign owd   = sel ? bus_fx.mem_wdata : bus_rr.mem_wdata;
  assign rd0   = sel ? bus_fx.m0_rdata  : bus_rr.m0_rdata;
  assign rd1   = sel ? bus_fx.m1_rdata  : bus_rr.m1_rdata;

  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        rst;
    logic        v0;
    logic [31:0] a0;
    logic        v1;
    logic [31:0] a1;
    logic [3:0]  k1;
    logic [31:0] d1;
    logic        er0;
    logic        er1;
    logic        ers;
    logic [3:0]  ewm;
    logic [31:0] eaddr;
    logic        c0;
    logic [31:0] erd0;
    logic        c1;
    logic [31:0] erd1;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(input logic rst, input logic v0_, input logic [31:0] a0_,
                              input logic v1_, input logic [31:0] a1_, input logic [3:0] k1_,
                              input logic [31:0] d1_, input logic er0, input logic er1,
                              input logic ers, input logic [3:0] ewm, input logic [31:0] eaddr,
                              input logic c0, input logic [31:0] erd0, input logic c1,
                              input logic [31:0] erd1);
    vec_t v;
    v.rst = rst; v.v0 = v0_; v.a0 = a0_; v.v1 = v1_; v.a1 = a1_; v.k1 = k1_; v.d1 = d1_;
    v.er0 = er0; v.er1 = er1; v.ers = ers; v.ewm = ewm; v.eaddr = eaddr;
    v.c0 = c0; v.erd0 = erd0; v.c1 = c1; v.erd1 = erd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle_start();
    @(negedge clk);
  endtask

  // RAM behaviour: what the arbiter drives before the edge acts at the edge.
  task automatic cycle_end();
    logic        cs;
    logic [3:0]  cw;
    logic [31:0] ca, cd;
    cs = rs; cw = wm; ca = oaddr; cd = owd;
    @(posedge clk);
    #1;
    if (cs) mem_rdata = ram[ca[9:2]];
    for (int b = 0; b < 4; b++) begin
      if (cw[b]) ram[ca[9:2]][8*b +: 8] = cd[8*b +: 8];
    end
  endtask

  task automatic contention(input logic fx);
    logic e0, e1;
    sel = fx;
    cycle_start();
    reset = 1'b1;
    v0 = 1'b1; a0 = 32'd400; k0 = 4'd0; d0 = 32'd0;
    v1 = 1'b1; a1 = 32'd408; k1 = 4'd0; d1 = 32'd0;
    #2;
    chk($sformatf("cont%0d reset m0_ready", fx), {31'd0, r0}, 32'd0);
    chk($sformatf("cont%0d reset m1_ready", fx), {31'd0, r1}, 32'd0);
    cycle_end();
    for (int k = 0; k < 12; k++) begin
      cycle_start();
      reset = 1'b0;
      v0 = fx ? (k < 6) : 1'b1;
      #2;
      if (fx) begin
        e0 = (k == 2) || (k == 5);
        e1 = (k == 8) || (k == 11);
      end else begin
        e0 = (k == 2) || (k == 8);
        e1 = (k == 5) || (k == 11);
      end
      chk($sformatf("cont%0d k%0d m0_ready", fx, k), {31'd0, r0}, {31'd0, e0});
      chk($sformatf("cont%0d k%0d m1_ready", fx, k), {31'd0, r1}, {31'd0, e1});
      if (e0) chk($sformatf("cont%0d k%0d m0_rdata", fx, k), rd0, W100);
      if (e1) chk($sformatf("cont%0d k%0d m1_rdata", fx, k), rd1, W102);
      cycle_end();
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  // Transaction-level model: the arbiter takes one request whenever it is free,
  // answers it two cycles later and is free again the cycle after that.
  task automatic rand_run(input logic fx, input int n);
    bit          pend [2];
    logic [31:0] pa [2], pd [2], hold [2];
    logic [3:0]  pk [2];
    bit          known [2];
    bit          t_active, last_w, t_m;
    int          t_issue, ph;
    logic [31:0] t_a, t_rd;
    logic [3:0]  t_k;
    logic        er [2];
    logic [31:0] rdm;
    sel = fx;
    cycle_start();
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0;
    #2;
    cycle_end();
    for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; hold[m] = 32'd0; known[m] = 1; pa[m] = 32'd0; pd[m] = 32'd0; pk[m] = 4'd0;
    end
    t_active = 0; last_w = 1; t_issue = 0; t_a = 32'd0; t_rd = 32'd0; t_k = 4'd0; t_m = 0;
    for (int c = 0; c < n; c++) begin
      cycle_start();
      reset = 1'b0;
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 1) == 1) begin
          pend[m] = 1;
          pa[m]   = 32'($urandom_range(96, 111)) * 32'd4;
          pk[m]   = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
          pd[m]   = $urandom;
        end
      end
      v0 = pend[0]; a0 = pend[0] ? pa[0] : $urandom; k0 = pk[0]; d0 = pd[0];
      v1 = pend[1]; a1 = pend[1] ? pa[1] : $urandom; k1 = pk[1]; d1 = pd[1];
      if (!t_active && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) t_m = fx ? 1'b0 : ~last_w;
        else                    t_m = pend[1];
        t_active = 1; t_issue = c; t_a = pa[t_m]; t_k = pk[t_m];
        if (t_k == 4'd0) begin
          t_rd = ref_mem[t_a[9:2]];
        end else begin
          for (int b = 0; b < 4; b++)
            if (t_k[b]) ref_mem[t_a[9:2]][8*b +: 8] = pd[t_m][8*b +: 8];
        end
      end
      ph = t_active ? (c - t_issue) : -1;
      er[0] = (ph == 2) && (t_m == 1'b0);
      er[1] = (ph == 2) && (t_m == 1'b1);
      #2;
      chk($sformatf("rnd%0d c%0d m0_ready", fx, c), {31'd0, r0}, {31'd0, er[0]});
      chk($sformatf("rnd%0d c%0d m1_ready", fx, c), {31'd0, r1}, {31'd0, er[1]});
      chk($sformatf("rnd%0d c%0d mem_rstrb", fx, c), {31'd0, rs},
          {31'd0, (ph == 1) && (t_k == 4'd0)});
      chk($sformatf("rnd%0d c%0d mem_wmask", fx, c), {28'd0, wm}, {28'd0, (ph == 1) ? t_k : 4'd0});
      if (ph >= 1) chk($sformatf("rnd%0d c%0d mem_addr", fx, c), oaddr, t_a);
      for (int m = 0; m < 2; m++) begin
        rdm = (m == 0) ? rd0 : rd1;
        if (er[m] && t_k == 4'd0)
          chk($sformatf("rnd%0d c%0d m%0d_rdata", fx, c, m), rdm, t_rd);
        else if (!er[m] && known[m])
          chk($sformatf("rnd%0d c%0d m%0d_rdata hold", fx, c, m), rdm, hold[m]);
      end
      if (ph == 2) begin
        pend[t_m] = 0;
        last_w    = t_m;
        if (t_k == 4'd0) begin
          hold[t_m] = t_rd; known[t_m] = 1;
        end else begin
          known[t_m] = 0;
        end
        t_active = 0;
      end
      cycle_end();
    end
    v0 = 1'b0; v1 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0; mem_rdata = 32'd0;
    v0 = 1'b0; a0 = 32'd0; d0 = 32'd0; k0 = 4'd0;
    v1 = 1'b0; a1 = 32'd0; d1 = 32'd0; k1 = 4'd0;
    for (int i = 0; i < 256; i++) ram[i] = (32'(i) * 32'h01010101) ^ 32'h5A00C300;
    ram[100] = W100; ram[101] = W101; ram[102] = W102;

    //          rst v0 a0   v1 a1   k1     d1            r0 r1 rs wm     addr c0 rd0  c1 rd1
    vt[0]  = mk(1, 0, 0,   0, 0,   4'h0, 32'h0,        0, 0, 0, 4'h0, 0,   1, 0,    1, 0);
    vt[1]  = mk(0, 0, 0,   0, 0,   4'h0, 32'h0,        0, 0, 0, 4'h0, 0,   1, 0,    1, 0);
    vt[2]  = mk(0, 1, 400, 0, 0,   4'h0, 32'h0,        0, 0, 0, 4'h0, 0,   1, 0,    1, 0);
    vt[3]  = mk(0, 1, 400, 0, 0,   4'h0, 32'h0,        0, 0, 1, 4'h0, 400, 1, 0,    1, 0);
    vt[4]  = mk(0, 1, 400, 0, 0,   4'h0, 32'h0,        1, 0, 0, 4'h0, 400, 1, W100, 1, 0);
    vt[5]  = mk(0, 0, 0,   1, 404, 4'h8, 32'hAA000000, 0, 0, 0, 4'h0, 400, 1, W100, 1, 0);
    vt[6]  = mk(0, 0, 0,   1, 404, 4'h8, 32'hAA000000, 0, 0, 0, 4'h8, 404, 1, W100, 1, 0);
    vt[7]  = mk(0, 0, 0,   1, 404, 4'h8, 32'hAA000000, 0, 1, 0, 4'h0, 404, 1, W100, 0, 0);
    vt[8]  = mk(0, 0, 0,   1, 404, 4'h0, 32'h0,        0, 0, 0, 4'h0, 404, 1, W100, 0, 0);
    vt[9]  = mk(0, 0, 0,   1, 404, 4'h0, 32'h0,        0, 0, 1, 4'h0, 404, 1, W100, 0, 0);
    vt[10] = mk(0, 0, 0,   1, 404, 4'h0, 32'h0,        0, 1, 0, 4'h0, 404, 1, W100, 1, WB);
    vt[11] = mk(0, 1, 400, 0, 0,   4'h0, 32'h0,        0, 0, 0, 4'h0, 404, 1, W100, 1, WB);
    vt[12] = mk(0, 1, 408, 0, 0,   4'h0, 32'h0,        0, 0, 1, 4'h0, 400, 1, W100, 1, WB);
    vt[13] = mk(0, 1, 408, 0, 0,   4'h0, 32'h0,        1, 0, 0, 4'h0, 400, 1, W100, 1, WB);
    vt[14] = mk(0, 1, 400, 0, 0,   4'h0, 32'h0,        0, 0, 0, 4'h0, 400, 1, W100, 1, WB);
    vt[15] = mk(1, 1, 400, 1, 408, 4'h0, 32'h0,        0, 0, 0, 4'h0, 400, 1, W100, 1, WB);
    vt[16] = mk(0, 0, 0,   1, 408, 4'h0, 32'h0,        0, 0, 0, 4'h0, 0,   1, 0,    1, 0);
    vt[17] = mk(0, 0, 0,   1, 408, 4'h0, 32'h0,        0, 0, 1, 4'h0, 408, 1, 0,    1, 0);
    vt[18] = mk(0, 0, 0,   1, 408, 4'h0, 32'h0,        0, 1, 0, 4'h0, 408, 1, 0,    1, W102);
    vt[19] = mk(0, 0, 0,   0, 0,   4'h0, 32'h0,        0, 0, 0, 4'h0, 408, 1, 0,    1, W102);

    for (int i = 0; i < 20; i++) begin
      cycle_start();
      reset = vt[i].rst;
      v0 = vt[i].v0; a0 = vt[i].a0; k0 = 4'd0; d0 = 32'd0;
      v1 = vt[i].v1; a1 = vt[i].a1; k1 = vt[i].k1; d1 = vt[i].d1;
      #2;
      chk($sformatf("v%0d m0_ready", i),  {31'd0, r0}, {31'd0, vt[i].er0});
      chk($sformatf("v%0d m1_ready", i),  {31'd0, r1}, {31'd0, vt[i].er1});
      chk($sformatf("v%0d mem_rstrb", i), {31'd0, rs}, {31'd0, vt[i].ers});
      chk($sformatf("v%0d mem_wmask", i), {28'd0, wm}, {28'd0, vt[i].ewm});
      chk($sformatf("v%0d mem_addr", i),  oaddr, vt[i].eaddr);
      if (vt[i].c0) chk($sformatf("v%0d m0_rdata", i), rd0, vt[i].erd0);
      if (vt[i].c1) chk($sformatf("v%0d m1_rdata", i), rd1, vt[i].erd1);
      cycle_end();
    end

    contention(1'b0);
    contention(1'b1);
    rand_run(1'b0, 600);
    rand_run(1'b1, 600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ROUND_ROBIN, default 1, meaning 1 = alternate priority on contention, 0 = fixed priority to master 0.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port m0_valid / m1_valid, input, 1, request pending from master 0 (CPU) / master 1 (loader/DMA).
REQ-005 SHALL have port m0_addr / m1_addr, input, 32, byte address.
REQ-006 SHALL have port m0_wdata / m1_wdata, input, 32, write data, already byte-lane aligned.
REQ-007 SHALL have port m0_wmask / m1_wmask, input, 4, byte write mask; 4'b0000 means a read.
REQ-008 SHALL have port m0_ready / m1_ready, output, 1, one-cycle completion pulse.
REQ-009 SHALL have port m0_rdata / m1_rdata, output, 32, read data, valid while the matching ready is high.
REQ-010 SHALL have port mem_addr, output, 32, address to the shared RAM.
REQ-011 SHALL have port mem_rstrb, output, 1, read strobe to the RAM.
REQ-012 SHALL have port mem_wdata, output, 32, write data to the RAM.
REQ-013 SHALL have port mem_wmask, output, 4, byte write enables to the RAM.
REQ-014 SHALL have port mem_rdata, input, 32, RAM read data, registered by the RAM one cycle after mem_rstrb.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, ACCESS and RESPOND; every transaction takes exactly 3 cycles, so throughput is at most one transaction per 3 cycles.
REQ-016 IDLE: if any valid is high, SHALL select a winner, latch its addr/wdata/wmask and a grant id into internal registers, and go to ACCESS; with no valid high it SHALL stay in IDLE.
REQ-017 Arbitration with only one valid high SHALL grant that master.
REQ-018 Arbitration with both valids high and ROUND_ROBIN=1 SHALL grant the master that was not granted last; with ROUND_ROBIN=0 it SHALL grant m0.
REQ-019 ACCESS: SHALL drive mem_addr and mem_wdata from the latched request for exactly one cycle, then go to RESPOND.
REQ-020 ACCESS: SHALL drive mem_rstrb=1 if the latched wmask is 0; otherwise it SHALL drive mem_wmask=latched wmask with mem_rstrb=0.
REQ-021 RESPOND: SHALL pulse ready for the granted master only, drive that master's rdata from mem_rdata, update last_grant, and return to IDLE.
REQ-022 A request seen in IDLE at cycle T SHALL get ready at T+2; write data is committed in RAM at the clock edge ending cycle T+1.
REQ-023 mem_rstrb and mem_wmask SHALL be 0 in IDLE and RESPOND; mem_addr and mem_wdata SHALL hold the latched values in every state.
REQ-024 mX_rdata SHALL hold its last delivered value until that master's next ready; for writes it SHALL present mem_rdata (don't-care).
REQ-025 Masters SHALL hold valid and the request fields stable until ready, then drop valid or present a new request in the following cycle.
REQ-026 Inputs that change after the IDLE latch SHALL NOT affect the transaction in flight.
REQ-027 The non-granted master SHALL keep waiting with no ready; it SHALL be arbitrated on the next IDLE cycle.
REQ-028 With ROUND_ROBIN=1 and continuous requests from both masters, grants SHALL alternate strictly, so no master waits more than one transaction.
REQ-029 The block SHALL NOT decode addresses; IO and RAM steering stays outside it.

Reset
REQ-030 On reset high at a clock edge, the state SHALL go to IDLE.
REQ-031 On reset, last_grant SHALL be set to 1, so m0 wins the first contention.
REQ-032 On reset, all latched request registers, mX_rdata, mem_addr and mem_wdata SHALL be 0.
REQ-033 During reset and in the cycle after it, mem_rstrb, mem_wmask, m0_ready and m1_ready SHALL be 0.
REQ-034 Reset asserted during ACCESS or RESPOND SHALL abort the transaction, with no ready pulse and no strobe in the following cycle; a write strobe already driven in ACCESS may have committed.

Verification
REQ-035 Single read: RAM word 100 = 32'h04030201; m0 reads addr 400 at cycle T -> mem_rstrb=1 at T+1, m0_ready=1 and m0_rdata=32'h04030201 at T+2, m1_ready never set.
REQ-036 Byte write then read: m1 writes addr 404, wdata 32'hAA00_0000, wmask 4'b1000; then m1 reads 404 -> m1_rdata=32'hAA070605 given initial word 32'h08070605.
REQ-037 Contention, ROUND_ROBIN=1: both valid from reset, m0 reads 400 and m1 reads 408 continuously for 4 transactions -> ready order m0, m1, m0, m1, each 3 cycles apart, with correct rdata per master.
REQ-038 Contention, ROUND_ROBIN=0: the same stimulus -> only m0 receives ready while m0_valid stays high; m1 is granted in the first IDLE after m0 drops valid.
REQ-039 Reset mid-operation: assert reset during ACCESS of an m0 read -> no m0_ready; after release, a pending m1 request completes in 3 cycles with correct data.
REQ-040 Stability: change m0_addr from 400 to 408 during ACCESS -> data returned is from 400, and mem_addr stays 400 through RESPOND.
